rr_router_arb: RTL and testbench

RR_ROUTER_ARB -- requirements
Module: rr_router_arb

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 34 +++
 rtl/rr_router_arb.sv | 114 +++++++++++
 tb/tb_rr_router_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin router arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } arb_state_e;

  localparam int NUM_IN_DEF  = 4;
  localparam int NUM_OUT_DEF = 4;
  localparam int RR_EN_DEF   = 1;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic dest_ok(input int d, input int n);
    return d < n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = NUM_IN_DEF,
  parameter int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int pos;
    logic [SW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos  = (int'(ptr_i) + k) % N;
      cand = SW'(pos);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/rr_router_arb.sv
// Router arbiter: pops one input FIFO per cycle, pushes its word one cycle later,
// with a drain handshake that quiesces the pop/push pipeline.
module rr_router_arb
  import arb_pkg::*;
#(
  parameter  int NUM_IN  = NUM_IN_DEF,
  parameter  int NUM_OUT = NUM_OUT_DEF,
  parameter  int RR_EN   = RR_EN_DEF,
  localparam int SW      = clog2_min1(NUM_IN),
  localparam int DW      = clog2_min1(NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN-1:0]    empty_in,
  input  logic [NUM_IN*DW-1:0] dest_in,
  input  logic [NUM_OUT-1:0]   almost_full_out,
  input  logic                 drain_req,
  output logic [NUM_IN-1:0]    pop,
  output logic [SW-1:0]        select,
  output logic [NUM_OUT-1:0]   push,
  output logic                 drain_ack
);

  arb_state_e         state_q, state_d;
  logic [NUM_IN-1:0]  pop_q, pop_d, req, win_gnt;
  logic [NUM_OUT-1:0] push_q, push_d;
  logic [SW-1:0]      select_q, select_d, rr_ptr_q, rr_ptr_d, pick_ptr, win_idx;
  logic [SW-1:0]      pend_src_q;
  logic [DW-1:0]      pend_dst_q, win_dst;
  logic               drain_ack_q, drain_ack_d, pend_valid_q, pend_valid_d;
  logic               win_any, fire;

  // A FIFO popped last edge is skipped so a single-entry FIFO is never popped twice.
  always_comb begin
    logic [DW-1:0] dst;
    req = '0;
    dst = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dst    = dest_in[i*DW +: DW];
      req[i] = !empty_in[i] && dest_ok(int'(dst), NUM_OUT) && !almost_full_out[dst] &&
               !pop_q[i] && (state_q == RUN);
    end
  end

  assign pick_ptr = (RR_EN != 0) ? rr_ptr_q : '0;

  rr_pick #(.N(NUM_IN), .SW(SW)) u_pick (
    .req_i (req),
    .ptr_i (pick_ptr),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign win_dst = dest_in[int'(win_idx)*DW +: DW];
  assign fire    = win_any && !drain_req;

  always_comb begin
    state_d      = state_q;
    pop_d        = fire ? win_gnt : '0;
    pend_valid_d = fire;
    rr_ptr_d     = rr_ptr_q;
    push_d       = '0;
    select_d     = select_q;
    if (fire) begin
      rr_ptr_d = (win_idx == SW'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
    end
    if (pend_valid_q) begin
      push_d   = NUM_OUT'(1) << pend_dst_q;
      select_d = pend_src_q;
    end
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!pend_valid_q && (pop_q == '0)) state_d = HALT;
      HALT:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
    drain_ack_d = (state_d == HALT);
  end

  // Pop stage -> push stage boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      pop_q        <= '0;
      push_q       <= '0;
      select_q     <= '0;
      drain_ack_q  <= 1'b0;
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop_d;
      push_q       <= push_d;
      select_q     <= select_d;
      drain_ack_q  <= drain_ack_d;
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      pend_src_q <= win_idx;
      pend_dst_q <= win_dst;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign select    = select_q;
  assign drain_ack = drain_ack_q;

endmodule

// File: tb/tb_rr_router_arb.sv
// Bench for rr_router_arb: directed table, corner sequences and random traffic vs a reference model.
module tb_rr_router_arb;

  localparam int S_RUN = 0, S_DRAIN = 1, S_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] empty_in, af;
  logic [7:0] dest;
  logic       drain;

  logic [3:0] pop_a, push_a, pop_b, push_b;
  logic [1:0] sel_a, sel_b;
  logic       ack_a, ack_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  int m_pop[2], m_push[2], m_sel[2], m_ack[2], m_ptr[2];
  int m_pv[2], m_psrc[2], m_pdst[2], m_st[2];

  always #5 clk = ~clk;

  rr_router_arb #(.NUM_IN(4), .NUM_OUT(4), .RR_EN(1)) dut (
    .clk(clk), .reset(rst_n), .empty_in(empty_in), .dest_in(dest),
    .almost_full_out(af), .drain_req(drain),
    .pop(pop_a), .select(sel_a), .push(push_a), .drain_ack(ack_a)
  );

  rr_router_arb #(.NUM_IN(4), .NUM_OUT(4), .RR_EN(0)) dut_fp (
    .clk(clk), .reset(rst_n), .empty_in(empty_in), .dest_in(dest),
    .almost_full_out(af), .drain_req(drain),
    .pop(pop_b), .select(sel_b), .push(push_b), .drain_ack(ack_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dest_of(input int i);
    logic [7:0] dv;
    dv = dest;
    return int'(dv[2*i +: 2]);
  endfunction

  task automatic model_step(input int m, input bit rr);
    int win, i, d, npush, nsel, nst;
    if (!rst_n) begin
      m_pop[m] = 0; m_push[m] = 0; m_sel[m] = 0; m_ack[m] = 0;
      m_ptr[m] = 0; m_pv[m] = 0; m_st[m] = S_RUN;
    end else begin
      win = -1;
      if (m_st[m] == S_RUN && !drain) begin
        for (int k = 0; k < 4; k++) begin
          i = rr ? (m_ptr[m] + k) % 4 : k;
          d = dest_of(i);
          if (win < 0 && !empty_in[i] && d < 4 && !af[d] && !m_pop[m][i]) win = i;
        end
      end
      npush = m_pv[m] ? (1 << m_pdst[m]) : 0;
      nsel  = m_pv[m] ? m_psrc[m] : m_sel[m];
      nst   = m_st[m];
      if (m_st[m] == S_RUN && drain) nst = S_DRAIN;
      else if (m_st[m] == S_DRAIN && m_pv[m] == 0 && m_pop[m] == 0) nst = S_HALT;
      else if (m_st[m] == S_HALT && !drain) nst = S_RUN;
      m_push[m] = npush;
      m_sel[m]  = nsel;
      m_st[m]   = nst;
      m_ack[m]  = (nst == S_HALT) ? 1 : 0;
      m_pv[m]   = (win >= 0) ? 1 : 0;
      if (win >= 0) begin
        m_psrc[m] = win;
        m_pdst[m] = dest_of(win);
        m_pop[m]  = 1 << win;
        if (rr) m_ptr[m] = (win + 1) % 4;
      end else begin
        m_pop[m] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    chk("model_pop_rr",  pop_a,  m_pop[0]);
    chk("model_push_rr", push_a, m_push[0]);
    chk("model_sel_rr",  sel_a,  m_sel[0]);
    chk("model_ack_rr",  ack_a,  m_ack[0]);
    chk("model_pop_fp",  pop_b,  m_pop[1]);
    chk("model_push_fp", push_b, m_push[1]);
    chk("model_sel_fp",  sel_b,  m_sel[1]);
    chk("model_ack_fp",  ack_b,  m_ack[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst_n;
    logic [3:0] pop;
    logic [3:0] push;
    logic [1:0] sel;
    bit         ack;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit found;
    logic prev_pop1;
    rst_n = 1'b0; empty_in = 4'b0000; dest = {2'd3, 2'd2, 2'd1, 2'd0}; af = 4'b0000; drain = 1'b0;

    tbl[0] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[3] = '{1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0};
    tbl[4] = '{1'b1, 4'b0010, 4'b0001, 2'd0, 1'b0};
    tbl[5] = '{1'b1, 4'b0100, 4'b0010, 2'd1, 1'b0};
    tbl[6] = '{1'b1, 4'b1000, 4'b0100, 2'd2, 1'b0};
    tbl[7] = '{1'b1, 4'b0001, 4'b1000, 2'd3, 1'b0};
    tbl[8] = '{1'b1, 4'b0010, 4'b0001, 2'd0, 1'b0};

    for (int v = 0; v < 9; v++) begin
      rst_n = tbl[v].rst_n;
      tick();
      chk("tbl_pop",  pop_a,  tbl[v].pop);
      chk("tbl_push", push_a, tbl[v].push);
      chk("tbl_sel",  sel_a,  tbl[v].sel);
      chk("tbl_ack",  ack_a,  tbl[v].ack);
    end

    // Backpressure on output 2 blocks input 2 until released.
    do_reset();
    af = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_pop2_blocked", pop_a[2], 1'b0);
    end
    af = 4'b0000;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      tick();
      if (pop_a[2]) found = 1'b1;
    end
    chk("bp_pop2_released", found, 1'b1);

    // A single active input is popped every other cycle.
    empty_in = 4'b1101;
    do_reset();
    prev_pop1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("single_toggle", pop_a[1], !prev_pop1);
      chk("single_push",   push_a,   prev_pop1 ? 4'b0010 : 4'b0000);
      prev_pop1 = pop_a[1];
    end

    // Drain during streaming, then resume.
    empty_in = 4'b0000;
    do_reset();
    tick(); tick(); tick();
    drain = 1'b1;
    tick();
    chk("drain_no_pop",    pop_a, 4'b0000);
    chk("drain_last_push", push_a != 4'b0000, 1'b1);
    chk("drain_ack_early", ack_a, 1'b0);
    tick();
    chk("drain_ack_set", ack_a, 1'b1);
    chk("drain_push_idle", push_a, 4'b0000);
    tick();
    chk("drain_ack_hold", ack_a, 1'b1);
    drain = 1'b0;
    tick();
    chk("drain_ack_clear", ack_a, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 3 && !found; c++) begin
      tick();
      if (pop_a != 4'b0000) found = 1'b1;
    end
    chk("drain_resume", found, 1'b1);

    // Drain request dropped while draining still visits HALT for one cycle.
    drain = 1'b1;
    tick();
    drain = 1'b0;
    tick();
    chk("drain_short_halt", ack_a, 1'b1);
    tick();
    chk("drain_short_exit", ack_a, 1'b0);

    // Reset cutting off a pop discards its push.
    do_reset();
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("cut_push_in_reset", push_a, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("cut_push_after", push_a, 4'b0000);
    chk("cut_first_pop",  pop_a,  4'b0001);

    // Fixed priority instance.
    empty_in = 4'b0110;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fp_alt", pop_b, (c % 2 == 0) ? 4'b0001 : 4'b1000);
    end
    empty_in = 4'b1110;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fp_single", pop_b, (c % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      empty_in = 4'($urandom_range(0, 15));
      dest     = 8'($urandom_range(0, 255));
      af       = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 19) == 0) drain = ~drain;
      rst_n    = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
